// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Owns the fetch PC (F), addresses a synchronous instruction ROM and presents
// the returned word to decode as an instruction/PC/valid triple.
// Handles stall (with a one-word hold buffer), flush, and branch/jump/jr
// redirects. It also flags misaligned jr targets and counts issued instructions.
module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 COUNT_W  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall_in,
    input  logic                flush_in,
    input  logic                branch_in,
    input  logic [15:0]         branch_off_in,
    input  logic                jump_in,
    input  logic [25:0]         jump_idx_in,
    input  logic                jr_in,
    input  logic [ADDR_W-1:0]   jr_addr_in,
    input  logic [ADDR_W-1:0]   redirect_pc_in,
    output logic [ADDR_W-1:0]   rom_addr_out,
    input  logic [INST_W-1:0]   rom_data_in,
    output logic [INST_W-1:0]   inst_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   pc_plus4_out,
    output logic                valid_out,
    output logic                align_err_out,
    output logic [COUNT_W-1:0]  issued_out
);

    // Architectural state
    logic [ADDR_W-1:0]  f_reg;
    logic [ADDR_W-1:0]  f_next;
    logic [ADDR_W-1:0]  pc_reg;
    logic               valid_reg;
    logic               align_err_reg;
    logic [COUNT_W-1:0] issued_reg;
    logic [COUNT_W-1:0] issued_next;
    logic [INST_W-1:0]  hold_reg;
    logic               hold_valid_reg;

    // Redirect datapath
    logic               redirect;
    logic               hold_stall;
    logic [ADDR_W-1:0]  redirect_base;
    logic [31:0]        branch_off_w;
    logic [ADDR_W-1:0]  branch_target;
    logic [27:0]        jump_idx_sh;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  jr_target;
    logic [ADDR_W-1:0]  redirect_target;

    assign redirect      = jr_in | jump_in | branch_in;
    // A redirect or flush overrides a stall for that edge.
    assign hold_stall    = stall_in & ~redirect & ~flush_in;
    assign redirect_base = redirect_pc_in + ADDR_W'(4);
    assign branch_off_w  = {{14{branch_off_in[15]}}, branch_off_in, 2'b00};
    assign branch_target = redirect_base + branch_off_w[ADDR_W-1:0];
    assign jump_idx_sh   = {jump_idx_in, 2'b00};
    assign jr_target     = {jr_addr_in[ADDR_W-1:2], 2'b00};

    // Jump target: low 28 bits come from the index, any upper bits from base.
    // Built per bit so narrow address widths (below 28) simply truncate.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_jump
            if (gi < 28) begin : g_low
                assign jump_target[gi] = jump_idx_sh[gi];
            end else begin : g_high
                assign jump_target[gi] = redirect_base[gi];
            end
        end
    endgenerate

    // Select redirect source and next fetch PC: redirect > stall > sequential.
    always_comb begin
        redirect_target = branch_target;
        if (jr_in) begin
            redirect_target = jr_target;
        end else if (jump_in) begin
            redirect_target = jump_target;
        end
        f_next = f_reg + ADDR_W'(4);
        if (redirect) begin
            f_next = redirect_target;
        end else if (hold_stall) begin
            f_next = f_reg;
        end
    end

    // Issued counter advances on every cycle a valid instruction leaves decode.
    always_comb begin
        issued_next = issued_reg;
        if (valid_reg && !stall_in) begin
            issued_next = issued_reg + COUNT_W'(1);
        end
    end

    // Fetch PC, alignment flag and issued counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            f_reg         <= RESET_PC;
            align_err_reg <= 1'b0;
            issued_reg    <= '0;
        end else begin
            f_reg         <= f_next;
            align_err_reg <= jr_in & (|jr_addr_in[1:0]);
            issued_reg    <= issued_next;
        end
    end

    // Decode register: advance when not held, else keep pc/valid stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
        end else if (!hold_stall) begin
            pc_reg    <= f_reg;
            valid_reg <= ~(flush_in | redirect);
        end
    end

    // Hold buffer: the ROM re-reads F while stalled, so the word belonging to
    // pc_out is captured on the first stalled edge and replayed until release.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
        end else if (!hold_stall) begin
            hold_valid_reg <= 1'b0;
        end else if (!hold_valid_reg) begin
            hold_reg       <= rom_data_in;
            hold_valid_reg <= 1'b1;
        end
    end

    assign rom_addr_out  = f_reg;
    assign inst_out      = hold_valid_reg ? hold_reg : rom_data_in;
    assign pc_out        = pc_reg;
    assign pc_plus4_out  = pc_reg + ADDR_W'(4);
    assign valid_out     = valid_reg;
    assign align_err_out = align_err_reg;
    assign issued_out    = issued_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations followed
// by randomized stimulus, all checked every cycle against a behavioural model.
module tb_fetch_unit;

    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int COUNT_W = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              stall_in = 1'b0;
    logic              flush_in = 1'b0;
    logic              branch_in = 1'b0;
    logic [15:0]       branch_off_in = '0;
    logic              jump_in = 1'b0;
    logic [25:0]       jump_idx_in = '0;
    logic              jr_in = 1'b0;
    logic [31:0]       jr_addr_in = '0;
    logic [31:0]       redirect_pc_in = '0;
    logic [31:0]       rom_addr_out;
    logic [31:0]       rom_data_in;
    logic [31:0]       inst_out;
    logic [31:0]       pc_out;
    logic [31:0]       pc_plus4_out;
    logic              valid_out;
    logic              align_err_out;
    logic [31:0]       issued_out;

    int checks = 0;
    int failures = 0;

    fetch_unit #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .COUNT_W(COUNT_W)
    ) dut (
        .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .branch_in(branch_in), .branch_off_in(branch_off_in),
        .jump_in(jump_in), .jump_idx_in(jump_idx_in),
        .jr_in(jr_in), .jr_addr_in(jr_addr_in), .redirect_pc_in(redirect_pc_in),
        .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
        .inst_out(inst_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
        .valid_out(valid_out), .align_err_out(align_err_out), .issued_out(issued_out)
    );

    always #5 clock = ~clock;

    // ROM contents are a scrambled function of the address, so any word
    // delivered for the wrong PC is detected.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // Synchronous ROM: registered read of the presented address.
    always @(posedge clock) rom_data_in <= rom_fn(rom_addr_out);

    // Behavioural model state
    logic [31:0] m_f = '0;
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_cnt = '0;

    // Model: apply the fetch rules to the inputs present at each rising edge.
    always @(posedge clock) begin
        logic        redir;
        logic [31:0] base;
        logic [31:0] tgt;
        if (reset) begin
            m_f = RESET_PC; m_pc = RESET_PC; m_valid = 1'b0; m_err = 1'b0; m_cnt = '0;
        end else begin
            redir = jr_in || jump_in || branch_in;
            base  = redirect_pc_in + 32'd4;
            if (jr_in)        tgt = jr_addr_in & ~32'h3;
            else if (jump_in) tgt = (base & 32'hF000_0000) | (32'(jump_idx_in) * 4);
            else              tgt = base + 32'($signed(branch_off_in)) * 4;
            if (m_valid && !stall_in) m_cnt = m_cnt + 1;
            m_err = jr_in && (jr_addr_in[1:0] != 2'b00);
            if (!(stall_in && !redir && !flush_in)) begin
                m_pc    = m_f;
                m_valid = !(flush_in || redir);
            end
            if (redir)                        m_f = tgt;
            else if (!(stall_in && !flush_in)) m_f = m_f + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Wait for the falling edge, compare every output against the model.
    task automatic step();
        @(negedge clock);
        chk("rom_addr", rom_addr_out, m_f);
        chk("pc", pc_out, m_pc);
        chk("pc_plus4", pc_plus4_out, m_pc + 32'd4);
        chk("valid", 32'(valid_out), 32'(m_valid));
        chk("align_err", 32'(align_err_out), 32'(m_err));
        chk("issued", issued_out, m_cnt);
        if (m_valid) chk("inst", inst_out, rom_fn(m_pc));
        $display("t=%0t rst=%0b stl=%0b fl=%0b br=%0b j=%0b jr=%0b addr=%h pc=%h v=%0b inst=%h err=%0b cnt=%0d",
                 $time, reset, stall_in, flush_in, branch_in, jump_in, jr_in,
                 rom_addr_out, pc_out, valid_out, inst_out, align_err_out, issued_out);
    endtask

    task automatic clear_redirects();
        branch_in = 1'b0; jump_in = 1'b0; jr_in = 1'b0; flush_in = 1'b0;
    endtask

    initial begin
        // Reset and release
        reset = 1'b1;
        step(); step();
        chk("lit_reset_addr", rom_addr_out, 32'h0);
        chk("lit_reset_valid", 32'(valid_out), 32'h0);
        chk("lit_reset_cnt", issued_out, 32'h0);
        reset = 1'b0;
        step();
        chk("lit_first_valid", 32'(valid_out), 32'h1);
        chk("lit_first_pc", pc_out, 32'h0);
        chk("lit_first_inst", inst_out, rom_fn(32'h0));
        chk("lit_addr4", rom_addr_out, 32'h4);
        step();
        step();
        chk("lit_addr12", rom_addr_out, 32'hC);
        chk("lit_pc8", pc_out, 32'h8);
        chk("lit_cnt2", issued_out, 32'h2);

        // Stall three cycles at pc_out=8
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_stall_inst", inst_out, rom_fn(32'h8));
            chk("lit_stall_addr", rom_addr_out, 32'hC);
            chk("lit_stall_cnt", issued_out, 32'h2);
        end
        stall_in = 1'b0;
        step();
        chk("lit_release_pc12", pc_out, 32'hC);
        step();
        chk("lit_release_pc16", pc_out, 32'h10);

        // Backward branch
        branch_in = 1'b1; redirect_pc_in = 32'h20; branch_off_in = 16'hFFFE;
        step();
        chk("lit_branch_addr", rom_addr_out, 32'h1C);
        chk("lit_branch_bubble", 32'(valid_out), 32'h0);
        clear_redirects();
        step();
        chk("lit_branch_valid", 32'(valid_out), 32'h1);
        chk("lit_branch_inst", inst_out, rom_fn(32'h1C));

        // Jump
        jump_in = 1'b1; jump_idx_in = 26'h40; redirect_pc_in = 32'h1000_0010;
        step();
        chk("lit_jump_addr", rom_addr_out, 32'h1000_0100);
        clear_redirects();
        step();

        // jr beats branch; misaligned target
        jr_in = 1'b1; branch_in = 1'b1; jr_addr_in = 32'h302;
        redirect_pc_in = 32'h20; branch_off_in = 16'hFFFE;
        step();
        chk("lit_jr_addr", rom_addr_out, 32'h300);
        chk("lit_jr_err", 32'(align_err_out), 32'h1);
        clear_redirects();
        step();
        chk("lit_jr_err_clear", 32'(align_err_out), 32'h0);
        chk("lit_jr_pc", pc_out, 32'h300);

        // Reset during a stall with the hold buffer full
        stall_in = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        chk("lit_rst_stall_addr", rom_addr_out, RESET_PC);
        chk("lit_rst_stall_valid", 32'(valid_out), 32'h0);
        chk("lit_rst_stall_cnt", issued_out, 32'h0);
        reset = 1'b0; stall_in = 1'b0;
        step();
        chk("lit_restart_pc", pc_out, RESET_PC);
        chk("lit_restart_inst", inst_out, rom_fn(RESET_PC));
        step();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            stall_in       = ($urandom_range(0, 99) < 25);
            flush_in       = ($urandom_range(0, 99) < 5);
            branch_in      = ($urandom_range(0, 99) < 6);
            jump_in        = ($urandom_range(0, 99) < 3);
            jr_in          = ($urandom_range(0, 99) < 3);
            branch_off_in  = 16'($urandom);
            jump_idx_in    = 26'($urandom);
            jr_addr_in     = $urandom;
            redirect_pc_in = $urandom & ~32'h3;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
